// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, mid-bit sampling.
// The serial line is brought into the clock domain by a two-flop synchronizer.
// A single timer paces the start-bit check, the eight data samples and the
// stop-bit sample. A stop bit sampled low parks the receiver in BREAK until
// the line returns high, so a held-low line reports one framing error only.
module uart_rx #(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200
) (
    input  logic       i_SysClock,
    input  logic       i_ResetN,
    input  logic       i_RxSerial,
    output logic [7:0] o_RxByte,
    output logic       o_RxValid,
    output logic       o_FrameErr,
    output logic       o_RxBusy
);

    localparam int CLKS_PER_BIT = SYS_CLOCK / UART_BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_BIT,
        ST_DATA_BITS,
        ST_STOP_BIT,
        ST_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        sync_meta_q, sync_meta_d;
    logic        rx_s_q, rx_s_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    // State register, synchronizer and datapath flops; the line flops idle high.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_q     <= ST_IDLE;
            sync_meta_q <= 1'b1;
            rx_s_q      <= 1'b1;
            timer_q     <= 16'd0;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_meta_q <= sync_meta_d;
            rx_s_q      <= rx_s_d;
            timer_q     <= timer_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
        end
    end

    // Next-state logic: timer restarts on every state change or target hit.
    always_comb begin
        state_d     = state_q;
        sync_meta_d = i_RxSerial;
        rx_s_d      = sync_meta_q;
        timer_d     = timer_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = 16'd0;
                if (!rx_s_q) begin
                    state_d = ST_START_BIT;
                end
            end

            ST_START_BIT: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = 16'd0;
                    if (!rx_s_q) begin
                        state_d  = ST_DATA_BITS;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            ST_DATA_BITS: begin
                if (timer_q == BIT_LAST) begin
                    timer_d           = 16'd0;
                    shift_d[bitcnt_q] = rx_s_q;
                    bitcnt_d          = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_STOP_BIT;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            ST_STOP_BIT: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = 16'd0;
                    if (rx_s_q) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            ST_BREAK: begin
                timer_d = 16'd0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = 16'd0;
            end
        endcase
    end

    assign o_RxByte   = byte_q;
    assign o_RxValid  = valid_q;
    assign o_FrameErr = ferr_q;
    assign o_RxBusy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Expected bytes are queued as frames are driven; a monitor pops and
// compares them whenever the receiver pulses o_RxValid.
module tb_uart_rx;

    localparam int SYS_CLOCK = 1600;
    localparam int BAUD      = 100;
    localparam int CPB       = 16;
    localparam int HALF      = 8;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int         checks      = 0;
    int         errors      = 0;
    int         valid_count = 0;
    int         ferr_count  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [7:0] last_good   = 8'h00;

    uart_rx #(
        .SYS_CLOCK     (SYS_CLOCK),
        .UART_BAUDRATE (BAUD)
    ) dut (
        .i_SysClock (clk),
        .i_ResetN   (rst_n),
        .i_RxSerial (rx),
        .o_RxByte   (rx_byte),
        .o_RxValid  (rx_valid),
        .o_FrameErr (frame_err),
        .o_RxBusy   (rx_busy)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    // Scoreboard monitor: every valid pulse must match the oldest queued byte
    always @(negedge clk) begin
        if (rx_valid || frame_err) begin
            checks++;
            if (rx_valid && frame_err) begin
                errors++;
                $display("[TB] FAIL valid_and_ferr: got valid=1 ferr=1, required never both high");
            end
        end
        if (frame_err) ferr_count++;
        if (rx_valid) begin
            valid_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got byte %02h, required no output", rx_byte);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rx_byte !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL sb_byte: got %02h, required %02h", rx_byte, mon_exp);
                end
            end
        end
    end

    // Global time limit so the run always ends
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got no finish by 3 ms, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one 8N1 frame, each bit held for 'period' clocks, no trailing gap
    task automatic drive_frame(input logic [7:0] data, input int period, input logic stop_val);
        logic [9:0] frame;
        frame = {stop_val, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            rx = frame[b];
            repeat (period - 1) @(negedge clk);
        end
    endtask

    // Hold the line high (idle) for n clocks
    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    // Byte an ideal mid-bit sampler reads: data bit n is taken
    // HALF + (n+1)*CPB clocks after the start edge, whatever the sender's rate.
    function automatic logic [7:0] model_byte(input logic [7:0] data, input int period);
        logic [7:0] r;
        int t, k;
        for (int n = 0; n < 8; n++) begin
            t = HALF + CPB * (n + 1);
            k = t / period;
            if (k == 0)      r[n] = 1'b0;
            else if (k <= 8) r[n] = data[k - 1];
            else             r[n] = 1'b1;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte: got %02h, required 00", rx_byte); end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", rx_valid); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b, required 0", frame_err); end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", rx_busy); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b, required 0", rx_busy); end
    endtask

    task automatic test_single_frame();
        int v0, f0, lat;
        v0  = valid_count;
        f0  = ferr_count;
        lat = 0;
        exp_q.push_back(8'hA5);
        fork
            drive_frame(8'hA5, CPB, 1'b1);
            begin
                wait (rx == 1'b0);
                while (!rx_valid && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        idle(2 * CPB);
        checks++;
        if (lat < 153 || lat > 155) begin
            errors++;
            $display("[TB] FAIL a5_latency: got %0d clk, required 154 +-1", lat);
        end
        checks++;
        if (valid_count - v0 != 1) begin errors++; $display("[TB] FAIL a5_pulses: got %0d, required 1", valid_count - v0); end
        checks++;
        if (ferr_count - f0 != 0) begin errors++; $display("[TB] FAIL a5_ferr: got %0d, required 0", ferr_count - f0); end
        checks++;
        if (rx_byte !== 8'hA5) begin errors++; $display("[TB] FAIL a5_held: got %02h, required a5", rx_byte); end
        last_good = 8'hA5;
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        logic [7:0] bytes [3];
        bytes = '{8'h00, 8'hFF, 8'h55};
        v0 = valid_count;
        f0 = ferr_count;
        for (int i = 0; i < 3; i++) exp_q.push_back(bytes[i]);
        for (int i = 0; i < 3; i++) drive_frame(bytes[i], CPB, 1'b1);
        idle(2 * CPB);
        checks++;
        if (valid_count - v0 != 3) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d, required 3", valid_count - v0); end
        checks++;
        if (ferr_count - f0 != 0) begin errors++; $display("[TB] FAIL b2b_ferr: got %0d, required 0", ferr_count - f0); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_pending: got %0d left, required 0", exp_q.size()); end
        last_good = 8'h55;
    endtask

    task automatic test_glitch();
        int v0, f0, busy_cnt;
        v0       = valid_count;
        f0       = ferr_count;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_busy) busy_cnt++;
            if (i == 0) rx = 1'b0;
            else if (i == 5) rx = 1'b1;
        end
        checks++;
        if (busy_cnt < 7 || busy_cnt > 9) begin errors++; $display("[TB] FAIL glitch_busy_len: got %0d clk, required about 8", busy_cnt); end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_end: got %b, required 0", rx_busy); end
        checks++;
        if (valid_count != v0 || ferr_count != f0) begin
            errors++;
            $display("[TB] FAIL glitch_output: got %0d valid %0d ferr, required 0 0", valid_count - v0, ferr_count - f0);
        end
    endtask

    task automatic test_frame_error();
        int v0, f0;
        v0 = valid_count;
        f0 = ferr_count;
        drive_frame(8'h3C, CPB, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        checks++;
        if (ferr_count - f0 != 1) begin errors++; $display("[TB] FAIL brk_ferr_count: got %0d, required 1", ferr_count - f0); end
        checks++;
        if (valid_count != v0) begin errors++; $display("[TB] FAIL brk_valid: got %0d, required 0", valid_count - v0); end
        checks++;
        if (rx_byte !== last_good) begin errors++; $display("[TB] FAIL brk_byte_kept: got %02h, required %02h", rx_byte, last_good); end
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL brk_busy: got %b, required 1", rx_busy); end
        idle(2 * CPB);
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL brk_release: got busy %b, required 0", rx_busy); end
        exp_q.push_back(8'h81);
        drive_frame(8'h81, CPB, 1'b1);
        idle(2 * CPB);
        checks++;
        if (valid_count - v0 != 1 || ferr_count - f0 != 1) begin
            errors++;
            $display("[TB] FAIL brk_recover: got %0d valid %0d ferr, required 1 1", valid_count - v0, ferr_count - f0);
        end
        checks++;
        if (rx_byte !== 8'h81) begin errors++; $display("[TB] FAIL brk_next_byte: got %02h, required 81", rx_byte); end
        last_good = 8'h81;
    endtask

    task automatic test_reset_midframe();
        int v0;
        v0 = valid_count;
        fork
            drive_frame(8'hC3, CPB, 1'b1);
            begin
                wait (rx == 1'b0);
                repeat (HALF + 5 * CPB) @(negedge clk);
                checks++;
                if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_busy: got %b, required 1", rx_busy); end
                rst_n = 1'b0;
                #1;
                checks++;
                if (rx_byte !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_byte: got %02h, required 00", rx_byte); end
                checks++;
                if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rst_mid_flags: got busy %b valid %b ferr %b, required 0 0 0", rx_busy, rx_valid, frame_err);
                end
            end
        join
        idle(CPB);
        rst_n = 1'b1;
        idle(2 * CPB);
        checks++;
        if (valid_count != v0 || rx_byte !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rst_discard: got %0d pulses byte %02h, required 0 pulses byte 00", valid_count - v0, rx_byte);
        end
        exp_q.push_back(8'h7E);
        drive_frame(8'h7E, CPB, 1'b1);
        idle(2 * CPB);
        checks++;
        if (rx_byte !== 8'h7E || valid_count - v0 != 1) begin
            errors++;
            $display("[TB] FAIL rst_next_frame: got %02h after %0d pulses, required 7e after 1", rx_byte, valid_count - v0);
        end
        last_good = 8'h7E;
    endtask

    task automatic test_baud_mismatch();
        int v0, f0;
        logic [7:0] e15;
        v0  = valid_count;
        f0  = ferr_count;
        e15 = model_byte(8'h96, 15);
        exp_q.push_back(e15);
        drive_frame(8'h96, 15, 1'b1);
        idle(2 * CPB);
        checks++;
        if (rx_byte !== e15) begin errors++; $display("[TB] FAIL baud15_byte: got %02h, required %02h", rx_byte, e15); end
        exp_q.push_back(8'h96);
        drive_frame(8'h96, 17, 1'b1);
        idle(2 * CPB);
        checks++;
        if (rx_byte !== 8'h96) begin errors++; $display("[TB] FAIL baud17_byte: got %02h, required 96", rx_byte); end
        checks++;
        if (valid_count - v0 != 2 || ferr_count != f0) begin
            errors++;
            $display("[TB] FAIL baud_pulses: got %0d valid %0d ferr, required 2 0", valid_count - v0, ferr_count - f0);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL final_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        test_baud_mismatch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
